// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Bus-ownership and memory-map controller for an 8085 system bus.
//
// Arbitration: two DMA requesters share the bus with the CPU through the
// HOLD/HLDA handshake. When both requesters are pending, the one that was not
// granted most recently wins (round-robin). Each grant is limited to MAX_GNT
// cycles, after which the bus is handed back to the CPU for at least one cycle.
//
// Memory map: RAM at 0x0000-0x00FF, ROM at 0x0100-0x01FF, nothing above.
// Per-region wait states are inserted by holding READY low; a memory strobe
// into the empty space raises a one-cycle bus_err pulse.
//
// Parameters:
//   ROM_WAIT  wait states on ROM accesses (0-15)
//   RAM_WAIT  wait states on RAM accesses (0-15)
//   MAX_GNT   longest DMA tenure in cycles (2-255)
//
// Ports:
//   clk       system clock, rising-edge
//   rst       asynchronous reset, active low
//   hold      HOLD request to the CPU
//   hlda      HLDA acknowledge from the CPU
//   dma_req   level-held bus requests, bit i = requester i
//   dma_gnt   one-hot bus grant
//   addr      address of the current bus master
//   rdn, wrn  active-low read / write strobes
//   iomn      1 = IO cycle, 0 = memory cycle
//   rom_csn   ROM chip select, active low
//   ram_csn   RAM chip select, active low
//   ready     READY to the bus master
//   bus_err   one-cycle pulse on a memory strobe to unmapped space
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 0,
    parameter int MAX_GNT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic        hold,
    input  logic        hlda,
    input  logic [1:0]  dma_req,
    output logic [1:0]  dma_gnt,
    input  logic [15:0] addr,
    input  logic        rdn,
    input  logic        wrn,
    input  logic        iomn,
    output logic        rom_csn,
    output logic        ram_csn,
    output logic        ready,
    output logic        bus_err
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [7:0] TENURE_LAST = 8'(MAX_GNT - 1);
    localparam logic [3:0] ROM_WAIT_W  = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_WAIT_W  = 4'(RAM_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HREQ  = 2'd1,
        GRANT = 2'd2,
        REL   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Arbitration state
    // -------------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic       sel_reg, sel_next;        // requester currently being served
    logic       last_reg, last_next;      // requester granted most recently
    logic [7:0] tenure_reg, tenure_next;  // cycles spent in GRANT
    logic       winner;
    logic       grant_active;

    // Round-robin choice. last_reg resets to 1 so requester 0 wins the first
    // contested arbitration after reset.
    always_comb begin
        winner = 1'b0;
        case (dma_req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_reg;
            default: winner = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            sel_reg    <= 1'b0;
            last_reg   <= 1'b1;
            tenure_reg <= 8'd0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            last_reg   <= last_next;
            tenure_reg <= tenure_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        last_next    = last_reg;
        tenure_next  = tenure_reg;
        hold         = 1'b0;
        grant_active = 1'b0;

        case (state_reg)
            IDLE: begin
                if (dma_req != 2'b00) begin
                    sel_next   = winner;
                    state_next = HREQ;
                end
            end

            HREQ: begin
                hold = 1'b1;
                // A requester that gives up before the CPU lets go of the bus
                // is dropped without ever seeing a grant.
                if (!dma_req[sel_reg]) begin
                    state_next = REL;
                end else if (hlda) begin
                    tenure_next = 8'd0;
                    state_next  = GRANT;
                end
            end

            GRANT: begin
                hold = 1'b1;
                // Gating with hlda removes the grant in the very cycle the CPU
                // takes the bus back, so dma_gnt never overlaps CPU ownership.
                grant_active = hlda;
                tenure_next  = tenure_reg + 8'd1;
                if (!hlda || !dma_req[sel_reg] || (tenure_reg == TENURE_LAST)) begin
                    state_next = REL;
                end
            end

            REL: begin
                last_next = sel_reg;
                // Waiting for hlda=0 and then passing through IDLE guarantees
                // the CPU at least one bus cycle between two DMA tenures.
                if (!hlda) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-hot grant decode
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign dma_gnt[gi] = grant_active & (sel_reg == 1'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Address decode (purely from addr)
    // -------------------------------------------------------------------------
    logic is_ram;
    logic is_rom;
    logic is_unmapped;

    assign is_ram      = (addr[15:8] == 8'h00);
    assign is_rom      = (addr[15:8] == 8'h01);
    assign is_unmapped = ~is_ram & ~is_rom;
    assign ram_csn     = ~is_ram;
    assign rom_csn     = ~is_rom;

    // -------------------------------------------------------------------------
    // Wait-state generator
    // -------------------------------------------------------------------------
    logic       strobe_idle;
    logic       idle_prev_reg;
    logic       strobe_start;
    logic [3:0] load_val;
    logic [3:0] wait_reg, wait_next;

    assign strobe_idle = rdn & wrn;

    // Start of a memory strobe: both strobes were high last cycle and one of
    // them is low now. Gated with rst so that nothing is flagged in reset.
    assign strobe_start = rst & idle_prev_reg & ~strobe_idle & ~iomn;

    always_comb begin
        load_val = 4'd0;
        if (is_rom) begin
            load_val = ROM_WAIT_W;
        end else if (is_ram) begin
            load_val = RAM_WAIT_W;
        end
    end

    // wait_reg holds the number of wait cycles still owed after the current
    // one. The strobe-start cycle is itself the first wait cycle (ready is
    // pulled low combinationally), hence the load of load_val-1.
    always_comb begin
        wait_next = wait_reg;
        if (strobe_start) begin
            wait_next = (load_val == 4'd0) ? 4'd0 : (load_val - 4'd1);
        end else if (strobe_idle) begin
            wait_next = 4'd0;
        end else if (wait_reg != 4'd0) begin
            wait_next = wait_reg - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_prev_reg <= 1'b1;
            wait_reg      <= 4'd0;
        end else begin
            idle_prev_reg <= strobe_idle;
            wait_reg      <= wait_next;
        end
    end

    assign ready   = ~((strobe_start && (load_val != 4'd0)) || (wait_reg != 4'd0));
    assign bus_err = strobe_start & is_unmapped;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter built with ROM_WAIT=2, RAM_WAIT=0, MAX_GNT=4.
// Inputs change 2 ns after each rising edge and outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        hlda;
    logic [1:0]  dma_req;
    logic [1:0]  dma_gnt;
    logic [15:0] addr;
    logic        rdn;
    logic        wrn;
    logic        iomn;
    logic        rom_csn;
    logic        ram_csn;
    logic        ready;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Hand-computed round-robin trace with dma_req=11 held and the CPU acking
    // HOLD one cycle later: HREQ, 4x GRANT, REL, IDLE, then the other side.
    logic [1:0] rr_gnt  [16] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                                 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
    logic       rr_hold [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    bus_arbiter #(
        .ROM_WAIT (2),
        .RAM_WAIT (0),
        .MAX_GNT  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .hlda    (hlda),
        .dma_req (dma_req),
        .dma_gnt (dma_gnt),
        .addr    (addr),
        .rdn     (rdn),
        .wrn     (wrn),
        .iomn    (iomn),
        .rom_csn (rom_csn),
        .ram_csn (ram_csn),
        .ready   (ready),
        .bus_err (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst     = 1'b1;
        hlda    = 1'b1;
        dma_req = 2'b11;
        addr    = 16'h0000;
        rdn     = 1'b1;
        wrn     = 1'b1;
        iomn    = 1'b0;

        // ---------------- reset ----------------
        #1 rst = 1'b0;
        #1;
        check("rst_hold", hold, 1'b0);
        check("rst_gnt", dma_gnt, 2'b00);
        check("rst_ready", ready, 1'b1);
        check("rst_buserr", bus_err, 1'b0);
        tick();
        tick();
        #1;
        check("rst_hold_clk", hold, 1'b0);
        check("rst_gnt_clk", dma_gnt, 2'b00);
        rdn  = 1'b0;
        addr = 16'h0150;
        #1;
        check("rst_ready_strobe", ready, 1'b1);
        addr = 16'h8000;
        #1;
        check("rst_buserr_strobe", bus_err, 1'b0);
        rdn  = 1'b1;
        addr = 16'h0000;
        hlda = 1'b0;
        tick();
        rst = 1'b1;

        // ---------------- round-robin with tenure limit ----------------
        for (int k = 0; k < 16; k++) begin
            tick();
            hlda = hold;
            #1;
            check($sformatf("rr_hold[%0d]", k + 1), hold, rr_hold[k]);
            check($sformatf("rr_gnt[%0d]", k + 1), dma_gnt, rr_gnt[k]);
        end
        dma_req = 2'b00;
        tick();
        hlda = hold;
        #1;
        check("rr_drop_gnt", dma_gnt, 2'b00);
        check("rr_drop_hold", hold, 1'b0);
        tick();

        // ---------------- single requester, slow HLDA ----------------
        dma_req = 2'b10;
        tick(); #1;
        check("single_hold_q1", hold, 1'b1);
        check("single_gnt_q1", dma_gnt, 2'b00);
        tick(); #1;
        check("single_gnt_q2", dma_gnt, 2'b00);
        tick(); #1;
        check("single_gnt_q3", dma_gnt, 2'b00);
        tick();
        hlda = 1'b1;
        #1;
        check("single_gnt_hlda", dma_gnt, 2'b00);
        tick(); #1;
        check("single_gnt_on", dma_gnt, 2'b10);
        check("single_hold_on", hold, 1'b1);
        tick();
        dma_req = 2'b00;
        #1;
        check("single_gnt_still", dma_gnt, 2'b10);
        tick(); #1;
        check("single_gnt_off", dma_gnt, 2'b00);
        check("single_hold_off", hold, 1'b0);
        tick(); #1;
        check("single_rel_hold", hold, 1'b0);
        hlda = 1'b0;
        tick();
        tick(); #1;
        check("single_idle_hold", hold, 1'b0);

        // ---------------- abort before HLDA ----------------
        dma_req = 2'b01;
        tick(); #1;
        check("abort_hold_up", hold, 1'b1);
        dma_req = 2'b00;
        tick(); #1;
        check("abort_hold_down", hold, 1'b0);
        check("abort_gnt_rel", dma_gnt, 2'b00);
        tick(); #1;
        check("abort_gnt_idle", dma_gnt, 2'b00);
        tick(); #1;
        check("abort_hold_idle", hold, 1'b0);

        // ---------------- HLDA drops during grant ----------------
        dma_req = 2'b01;
        tick();
        hlda = 1'b1;
        #1;
        check("perr_gnt_hreq", dma_gnt, 2'b00);
        tick(); #1;
        check("perr_gnt_on", dma_gnt, 2'b01);
        hlda    = 1'b0;
        dma_req = 2'b00;
        #1;
        check("perr_gnt_same_cycle", dma_gnt, 2'b00);
        tick(); #1;
        check("perr_hold_rel", hold, 1'b0);
        tick();

        // ---------------- ROM read with 2 wait states ----------------
        addr = 16'h0150;
        rdn  = 1'b0;
        #1;
        check("rom_csn", rom_csn, 1'b0);
        check("rom_ram_csn", ram_csn, 1'b1);
        check("rom_ready_w0", ready, 1'b0);
        check("rom_buserr", bus_err, 1'b0);
        tick(); #1;
        check("rom_ready_w1", ready, 1'b0);
        tick(); #1;
        check("rom_ready_done", ready, 1'b1);
        tick(); #1;
        check("rom_ready_hold", ready, 1'b1);
        rdn = 1'b1;
        tick();

        // ---------------- RAM read, no wait states ----------------
        addr = 16'h0020;
        rdn  = 1'b0;
        #1;
        check("ram_csn", ram_csn, 1'b0);
        check("ram_rom_csn", rom_csn, 1'b1);
        check("ram_ready_w0", ready, 1'b1);
        tick(); #1;
        check("ram_ready_w1", ready, 1'b1);
        rdn = 1'b1;
        tick();

        // ---------------- unmapped write ----------------
        addr = 16'h8000;
        wrn  = 1'b0;
        #1;
        check("unm_buserr", bus_err, 1'b1);
        check("unm_ready", ready, 1'b1);
        check("unm_rom_csn", rom_csn, 1'b1);
        check("unm_ram_csn", ram_csn, 1'b1);
        tick(); #1;
        check("unm_buserr_pulse", bus_err, 1'b0);
        wrn = 1'b1;
        tick();

        // ---------------- IO cycles ----------------
        iomn = 1'b1;
        wrn  = 1'b0;
        #1;
        check("io_buserr", bus_err, 1'b0);
        check("io_ready", ready, 1'b1);
        wrn = 1'b1;
        tick();
        addr = 16'h0150;
        rdn  = 1'b0;
        #1;
        check("io_rom_ready", ready, 1'b1);
        tick(); #1;
        check("io_rom_ready_w1", ready, 1'b1);
        rdn  = 1'b1;
        iomn = 1'b0;
        tick();

        // ---------------- decode boundaries ----------------
        addr = 16'h00FF; #1;
        check("dec_00ff_ram", ram_csn, 1'b0);
        check("dec_00ff_rom", rom_csn, 1'b1);
        addr = 16'h0100; #1;
        check("dec_0100_rom", rom_csn, 1'b0);
        check("dec_0100_ram", ram_csn, 1'b1);
        addr = 16'h01FF; #1;
        check("dec_01ff_rom", rom_csn, 1'b0);
        addr = 16'h0200; #1;
        check("dec_0200_rom", rom_csn, 1'b1);
        check("dec_0200_ram", ram_csn, 1'b1);
        wrn = 1'b0;
        #1;
        check("dec_0200_buserr", bus_err, 1'b1);
        tick();
        wrn = 1'b1;
        tick();

        // ---------------- async reset mid-grant, mid-wait ----------------
        dma_req = 2'b01;
        tick();
        hlda = 1'b1;
        tick();
        addr = 16'h0150;
        rdn  = 1'b0;
        #1;
        check("arst_pre_gnt", dma_gnt, 2'b01);
        check("arst_pre_ready", ready, 1'b0);
        tick(); #1;
        check("arst_pre_ready_w1", ready, 1'b0);
        rst = 1'b0;
        #1;
        check("arst_hold", hold, 1'b0);
        check("arst_gnt", dma_gnt, 2'b00);
        check("arst_ready", ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Bus-ownership controller for the 8085 system bus. Shares the bus between the CPU and two DMA requesters using the CPU HOLD/HLDA handshake.
- Arbitration between the two requesters is round-robin, and each grant has a bounded tenure.
- Also owns the memory map and the READY line: it decodes chip selects for the 256-byte RAM (0x0000–0x00FF) and the 256-byte ROM (0x0100–0x01FF), and inserts per-region wait states. Accesses to the empty space (0x0200–0xFFFF) are flagged.

Parameters:
- ROM_WAIT, 1, wait states inserted on ROM accesses (0–15).
- RAM_WAIT, 0, wait states inserted on RAM accesses (0–15).
- MAX_GNT, 64, maximum number of cycles a DMA grant may be held (2–255).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- hold, output, 1, HOLD request to the CPU.
- hlda, input, 1, HLDA acknowledge from the CPU.
- dma_req, input, 2, bus requests; bit i belongs to requester i. A request is level-held.
- dma_gnt, output, 2, one-hot bus grant.
- addr, input, 16, address of the current bus master.
- rdn, input, 1, active-low read strobe.
- wrn, input, 1, active-low write strobe.
- iomn, input, 1, 1 = IO cycle, 0 = memory cycle.
- rom_csn, output, 1, ROM chip select, active-low.
- ram_csn, output, 1, RAM chip select, active-low.
- ready, output, 1, READY to the bus master.
- bus_err, output, 1, one-cycle pulse on a memory access to unmapped space.

Behaviour:

Reset:
- While rst=0: hold=0, dma_gnt=00, ready=1, bus_err=0.
- FSM is in IDLE, the round-robin pointer is 1 (requester 0 has priority next), and the wait and tenure counters are 0.
- Reset mid-grant or mid-wait drops hold, dma_gnt and the wait state immediately (asynchronously).

Arbitration FSM (states IDLE, HREQ, GRANT, REL):
- **IDLE**
  - If dma_req≠00, select the winner:
    - If exactly one bit is set, that requester wins.
    - If both are set, the requester other than the last-granted one wins.
  - Latch the winner in sel, set hold=1, go to HREQ.
- **HREQ**
  - hold=1; wait for hlda=1.
  - When hlda=1 and dma_req[sel]=1: on the next cycle dma_gnt[sel]=1, tenure counter is cleared, go to GRANT.
  - If dma_req[sel] drops before hlda rises: go to REL without granting.
- **GRANT**
  - dma_gnt[sel]=1 and the tenure counter increments each cycle.
  - Exit to REL when dma_req[sel]=0, or when the counter reaches MAX_GNT−1 (forced release).
  - If hlda falls while in GRANT (protocol error), dma_gnt is dropped the same cycle and the FSM goes to REL.
- **REL**
  - dma_gnt=00 and hold=0; the last-granted pointer is updated to sel.
  - Wait for hlda=0, then go to IDLE.
  - Re-arbitration happens at the earliest one cycle after returning to IDLE, so the CPU gets at least one bus cycle between grants.
- A requester still asserting after a forced release re-competes normally and loses to the other requester if both are pending.
- Invariants: dma_gnt is never nonzero unless hold=1 and hlda=1; at most one dma_gnt bit is set.

Decode (combinational, from addr only):
- ram_csn=0 iff addr[15:8]=0x00.
- rom_csn=0 iff addr[15:8]=0x01.
- Both are 1 otherwise.

Wait states:
- Strobe start is detected on the clock where (rdn&wrn) was 1 on the previous cycle and is 0 now, with iomn=0.
- At strobe start the wait counter is loaded with RAM_WAIT or ROM_WAIT according to the decoded region.
  - ready is 0 while the counter is nonzero (combinationally, starting the same cycle), and the counter decrements each cycle.
  - ready returns to 1 once the counter reaches 0. A wait value of 0 means ready stays 1.
- At a strobe start to unmapped space: no wait, ready stays 1, bus_err=1 for exactly that one cycle.
- IO cycles (iomn=1) never insert waits and never raise bus_err.
- If the strobe deasserts early, the counter is cleared and ready returns to 1 the next cycle.

Test Plan:
- Reset: rst=0 with dma_req=11 and hlda=1 → hold=0, dma_gnt=00, ready=1. Release rst with dma_req=11 → hold=1, and after hlda=1, dma_gnt=01.
- Single requester: dma_req=10, hlda rises 3 cycles after hold → dma_gnt=10 one cycle after hlda. Drop dma_req → dma_gnt=00 and hold=0 next cycle, then IDLE after hlda=0.
- Round-robin plus tenure limit: dma_req=11 held continuously with MAX_GNT=4 → grants alternate 01,10,01,… Each grant lasts exactly 4 cycles, and hold drops between grants.
- Abort: dma_req=01, then dma_req=00 before hlda → no dma_gnt pulse ever, hold returns to 0.
- ROM read: ROM_WAIT=2, addr=0x0150, iomn=0, rdn falls → rom_csn=0, ready=0 for 2 cycles then 1. Same read at 0x0020 with RAM_WAIT=0 → ram_csn=0, ready stays 1.
- Unmapped and IO: wrn falls at addr=0x8000 with iomn=0 → bus_err=1 for one cycle, ready=1, both chip selects high. Repeat with iomn=1 → bus_err stays 0.
